// File: rtl/matvec3_stream_driver.sv
// matvec3_stream_driver
// Initiator-side driver for the 3x3 matrix-vector core. Holds a host-written
// matrix and vector, streams them into the core on start (with new_matrix
// framing on the first word), collects the three results and exposes them on
// a small read port.
//
// Handshake rule for both ports: a word moves on a rising edge where
// valid=1 and ready=1. The sender keeps valid high and data stable until
// that edge; valid never depends combinationally on ready.
module matvec3_stream_driver #(
    parameter int IN_W  = 14,
    parameter int OUT_W = 28
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_we,
    input  logic [3:0]       cfg_addr,
    input  logic [IN_W-1:0]  cfg_wdata,
    input  logic             start,
    input  logic             start_new_matrix,
    output logic             busy,
    output logic             done,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [IN_W-1:0]  m_data,
    output logic             m_new_matrix,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [OUT_W-1:0] s_data,
    input  logic [1:0]       res_addr,
    output logic [OUT_W-1:0] res_data,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DRAIN  = 2'd2
    } state_t;

    state_t              state_q;
    logic [IN_W-1:0]     elem_q [0:11];
    logic [OUT_W-1:0]    res_q  [0:2];
    logic [3:0]          idx_q;        // buffer index of the word on m_data
    logic [1:0]          rcv_cnt_q;
    logic                send_mat_q;
    logic                mat_loaded_q;
    logic                mat_dirty_q;
    logic                m_valid_q;
    logic [IN_W-1:0]     m_data_q;
    logic                m_nm_q;
    logic                done_q;

    logic                send_xfer;
    logic                rcv_xfer;
    logic                rcv_all;
    logic                send_mat_now;
    logic [3:0]          start_idx;
    logic [3:0]          next_idx;

    assign busy         = (state_q != S_IDLE);
    assign s_ready      = busy && (rcv_cnt_q != 2'd3);
    assign m_valid      = m_valid_q;
    assign m_data       = m_data_q;
    assign m_new_matrix = m_nm_q;
    assign done         = done_q;
    assign dbg_state    = state_q;

    assign send_xfer    = m_valid_q && m_ready;
    assign rcv_xfer     = s_valid && s_ready;
    // All three results are in, counting a capture happening at this edge.
    assign rcv_all      = (rcv_cnt_q == 2'd3) || (rcv_xfer && (rcv_cnt_q == 2'd2));
    // A stale or never-sent matrix forces a full 12-word job.
    assign send_mat_now = start_new_matrix | mat_dirty_q | ~mat_loaded_q;
    assign start_idx    = send_mat_now ? 4'd0 : 4'd9;
    assign next_idx     = idx_q + 4'd1;

    // Result read port; address 3 reads zero.
    always_comb begin
        res_data = '0;
        case (res_addr)
            2'd0:    res_data = res_q[0];
            2'd1:    res_data = res_q[1];
            2'd2:    res_data = res_q[2];
            default: res_data = '0;
        endcase
    end

    // Job FSM together with buffer writes, result capture and the send register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            rcv_cnt_q    <= '0;
            send_mat_q   <= 1'b0;
            mat_loaded_q <= 1'b0;
            mat_dirty_q  <= 1'b0;
            m_valid_q    <= 1'b0;
            m_data_q     <= '0;
            m_nm_q       <= 1'b0;
            done_q       <= 1'b0;
            for (int i = 0; i < 12; i++) elem_q[i] <= '0;
            for (int i = 0; i < 3; i++)  res_q[i]  <= '0;
        end else begin
            done_q <= 1'b0;

            // Host writes land only between jobs.
            if (cfg_we && (cfg_addr < 4'd12) && (state_q == S_IDLE)) begin
                elem_q[cfg_addr] <= cfg_wdata;
                if (cfg_addr < 4'd9) mat_dirty_q <= 1'b1;
            end

            // Results may arrive while input is still streaming.
            if (rcv_xfer) begin
                for (int i = 0; i < 3; i++)
                    if (rcv_cnt_q == 2'(i)) res_q[i] <= s_data;
                rcv_cnt_q <= rcv_cnt_q + 2'd1;
            end

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        send_mat_q <= send_mat_now;
                        idx_q      <= start_idx;
                        m_valid_q  <= 1'b1;
                        m_data_q   <= elem_q[start_idx];
                        m_nm_q     <= send_mat_now;
                        rcv_cnt_q  <= '0;
                        state_q    <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (send_xfer) begin
                        if (idx_q == 4'd11) begin
                            m_valid_q <= 1'b0;
                            m_nm_q    <= 1'b0;
                            if (send_mat_q) begin
                                mat_loaded_q <= 1'b1;
                                mat_dirty_q  <= 1'b0;
                            end
                            if (rcv_all) begin
                                state_q <= S_IDLE;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= S_DRAIN;
                            end
                        end else begin
                            idx_q    <= next_idx;
                            m_data_q <= elem_q[next_idx];
                            m_nm_q   <= 1'b0;
                        end
                    end
                end
                S_DRAIN: begin
                    if (rcv_xfer && (rcv_cnt_q == 2'd2)) begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/matvec3_stream_driver.md
Name: matvec3_stream_driver

Overview:
- Initiator-side driver for the 3x3 matrix-vector core (matvec3_part2).
- Holds a host-written 3x3 matrix and 3-vector in local registers. On start it streams them into the core's input valid/ready port with the correct new_matrix framing.
- Consumes the core's 3 output values through the output valid/ready port and exposes them on a result read port.
- Used by block-level benches and by the system wrapper that sequences jobs into the core.

Parameters:
- IN_W, 14, width of a matrix/vector element (signed).
- OUT_W, 28, width of a result (signed).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- cfg_we  in  1  host write strobe for the element buffer.
- cfg_addr  in  4  0-8 = matrix row-major (m00,m01,m02,m10..m22); 9-11 = vector x0..x2; 12-15 ignored.
- cfg_wdata  in  IN_W  element written on cfg_we.
- start  in  1  one-cycle pulse that launches a job.
- start_new_matrix  in  1  sampled with start; 1 = send matrix plus vector, 0 = vector only.
- busy  out  1  job in progress.
- done  out  1  one-cycle pulse when all 3 results are captured.
- m_valid  out  1  to core input_valid.
- m_ready  in  1  from core input_ready.
- m_data  out  IN_W  to core input_data.
- m_new_matrix  out  1  to core new_matrix.
- s_valid  in  1  from core output_valid.
- s_ready  out  1  to core output_ready.
- s_data  in  OUT_W  from core output_data.
- res_addr  in  2  selects result 0-2; 3 reads 0.
- res_data  out  OUT_W  combinational read of the selected result.

Behaviour:
- Reset values:
  - busy=0, done=0, m_valid=0, m_data=0, m_new_matrix=0, s_ready=0.
  - Element buffer, results, counters and the mat_loaded flag all cleared to 0.
- Reset mid-job aborts the job immediately; no partial word is held.
- Element buffer:
  - A write with cfg_we=1 and cfg_addr<12 updates the register at the next edge, only while busy=0. Writes while busy are dropped.
  - Any matrix write (addr 0-8) sets mat_dirty.
- Job launch:
  - start while busy=0 → busy=1 at the next edge.
  - start while busy=1 is ignored.
  - send_mat = start_new_matrix | mat_dirty | ~mat_loaded. The first job after reset always sends the matrix.
  - Word count N = 12 if send_mat, else 3.
- States: IDLE → STREAM → DRAIN → IDLE.
  - IDLE: waits for start.
  - STREAM: sends words.
  - DRAIN: all words sent, waiting for remaining results.
  - STREAM goes directly to IDLE if 3 results are already captured when the last word is accepted.
- Send side:
  - m_valid=1 from the cycle after start until the N-th word transfers (m_valid & m_ready at an edge).
  - Word order: if send_mat, m00..m22 then x0..x2; otherwise x0..x2.
  - m_new_matrix = send_mat on the first word, 0 on all others.
  - m_data and m_new_matrix are registered and hold stable while m_valid=1 and m_ready=0.
  - The next word is presented the cycle after a transfer, so zero-bubble streaming is possible when m_ready stays high.
  - When the last word transfers, m_valid drops at that edge.
  - On completion of a matrix send: mat_loaded=1, mat_dirty=0.
- Receive side:
  - s_ready=1 whenever busy=1 and rcv_cnt<3, including during STREAM, because the core may emit results before input finishes.
  - A transfer (s_valid & s_ready) stores s_data into result[rcv_cnt] and increments rcv_cnt.
  - s_ready falls the edge after the 3rd capture. Extra s_valid after that is never accepted.
- Completion:
  - At the edge where both the last send and the 3rd receive have occurred (same or separate cycles): busy→0, and done=1 for exactly the following cycle.
  - Results hold until overwritten by the next job's captures.
  - A new start is accepted in the same cycle done=1.
- Simultaneous events: send and receive transfers in the same cycle are both honoured. A cfg write in the same cycle as start is still accepted, because busy=0 at that edge, but the word stream uses the updated value only if the write precedes start by at least one cycle.
- No arithmetic is performed; data passes through unmodified (signed, no extension).

Test Plan:
- Reset, then load M=[10,-20,30; 50,-60,70; 80,100,-110], x=[40,30,-20], start with start_new_matrix=1, m_ready/s_ready partner always ready:
  - 12 words stream back-to-back, m_new_matrix=1 only on word 0.
  - Results are -800, -1200, 8400; done pulses once.
- Then write x=[1,2,3], start with start_new_matrix=0:
  - Exactly 3 words, m_new_matrix=0.
  - Results are 60, 140, -50.
- Random m_ready stall pattern (about 50% low):
  - m_data and m_new_matrix never change while m_valid=1 and m_ready=0.
  - Word order is identical to the no-stall case.
- After reset, start with start_new_matrix=0:
  - The matrix is still sent (12 words, first flagged 1).
- Write m11=1 after a completed job, then start with start_new_matrix=0:
  - 12 words are sent (mat_dirty honoured).
  - cfg writes and extra start pulses during busy change nothing.
- Assert reset while in STREAM after 5 words:
  - m_valid=0, busy=0, s_ready=0 the next cycle; results read 0.
  - No done pulse.
